// File: rtl/puzzle_build_sequencer.sv
// Puzzle-build sequencer: photo rows -> rescale filter -> constraint generator.
// Define SEQ_TIMEOUT_EN to enable the drain-state watchdog (TIMEOUT_CYCLES).
module puzzle_build_sequencer #(
   parameter int SRC_ROWS       = 240,
   parameter int DST_ROWS       = 30,
   parameter int CON_LINES      = 70,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic       start_in,
   input  logic       abort_in,
   output logic       src_rd_en_out,
   output logic [8:0] src_row_idx_out,
   output logic       filter_start_out,
   output logic       filter_row_valid_out,
   input  logic       filter_outputing_in,
   input  logic       filter_done_in,
   output logic       rescale_wr_en_out,
   output logic [4:0] rescale_wr_idx_out,
   output logic       gen_rd_en_out,
   output logic [4:0] gen_row_idx_out,
   output logic       gen_start_out,
   output logic       gen_row_valid_out,
   input  logic       gen_outputing_in,
   input  logic       gen_done_in,
   output logic       con_wr_en_out,
   output logic [6:0] con_wr_idx_out,
   output logic [2:0] state_out,
   output logic       busy_out,
   output logic       done_out,
   output logic       err_out,
   output logic [1:0] err_code_out
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_FEED_FILT  = 3'd1,
      S_DRAIN_FILT = 3'd2,
      S_FEED_GEN   = 3'd3,
      S_DRAIN_GEN  = 3'd4,
      S_DONE       = 3'd5,
      S_ERROR      = 3'd6
   } state_t;

   localparam logic [8:0] SRC_LAST = 9'(SRC_ROWS - 1);
   localparam logic [4:0] DST_LAST = 5'(DST_ROWS - 1);
   localparam logic [4:0] DST_CNT  = 5'(DST_ROWS);
   localparam logic [6:0] CON_CNT  = 7'(CON_LINES);

   localparam logic [1:0] E_EARLY = 2'd1;
   localparam logic [1:0] E_COUNT = 2'd2;
   localparam logic [1:0] E_TMO   = 2'd3;

   state_t     state_q;
   logic       src_rd_q;
   logic [8:0] src_idx_q;
   logic       fstart_q;
   logic       fvalid_q;
   logic       gen_rd_q;
   logic [4:0] gen_idx_q;
   logic       gstart_q;
   logic       gvalid_q;
   logic [4:0] fcnt_q;
   logic [4:0] fcnt_d;
   logic [6:0] ccnt_q;
   logic [6:0] ccnt_d;
   logic       done_q;
   logic       err_q;
   logic [1:0] code_q;

   logic       f_acc;
   logic       g_acc;
   logic       wd_trip;

   always_comb begin
      f_acc = filter_outputing_in &&
              ((state_q == S_FEED_FILT) || (state_q == S_DRAIN_FILT));
      g_acc = gen_outputing_in &&
              ((state_q == S_FEED_GEN) || (state_q == S_DRAIN_GEN));
   end

   // Counts keep running past the store size so the done check can
   // see an overrun; they saturate at the counter width.
   always_comb begin
      fcnt_d = fcnt_q;
      if (f_acc && (fcnt_q != 5'd31)) begin
         fcnt_d = fcnt_q + 5'd1;
      end
      ccnt_d = ccnt_q;
      if (g_acc && (ccnt_q != 7'd127)) begin
         ccnt_d = ccnt_q + 7'd1;
      end
   end

`ifdef SEQ_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

   logic [WDW-1:0] wd_q;
   logic           in_drain;

   always_comb begin
      in_drain = (state_q == S_DRAIN_FILT) ||
                 (state_q == S_DRAIN_GEN);
   end

   // wd_q holds cycles elapsed since the last output strobe.
   always_ff @(posedge clk_in) begin
      if (reset_in || !in_drain || f_acc || g_acc) begin
         wd_q <= WDW'(1);
      end else if (wd_q != WD_LAST) begin
         wd_q <= wd_q + 1'b1;
      end
   end

   always_comb begin
      wd_trip = in_drain && !f_acc && !g_acc &&
                (wd_q == WD_LAST);
   end
`else
   logic unused_timeout;

   always_comb begin
      unused_timeout = (TIMEOUT_CYCLES > 0);
      wd_trip        = 1'b0;
   end
`endif

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q   <= S_IDLE;
         src_rd_q  <= 1'b0;
         src_idx_q <= '0;
         fstart_q  <= 1'b0;
         fvalid_q  <= 1'b0;
         gen_rd_q  <= 1'b0;
         gen_idx_q <= '0;
         gstart_q  <= 1'b0;
         gvalid_q  <= 1'b0;
         fcnt_q    <= '0;
         ccnt_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= '0;
      end else if (abort_in) begin
         state_q   <= S_IDLE;
         src_rd_q  <= 1'b0;
         src_idx_q <= '0;
         fstart_q  <= 1'b0;
         fvalid_q  <= 1'b0;
         gen_rd_q  <= 1'b0;
         gen_idx_q <= '0;
         gstart_q  <= 1'b0;
         gvalid_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         fstart_q <= 1'b0;
         gstart_q <= 1'b0;
         done_q   <= 1'b0;
         fvalid_q <= src_rd_q;
         gvalid_q <= gen_rd_q;
         fcnt_q   <= fcnt_d;
         ccnt_q   <= ccnt_d;
         unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start_in) begin
                  state_q   <= S_FEED_FILT;
                  fstart_q  <= 1'b1;
                  src_idx_q <= '0;
                  gen_idx_q <= '0;
                  fcnt_q    <= '0;
                  ccnt_q    <= '0;
                  err_q     <= 1'b0;
                  code_q    <= '0;
               end
            end
            S_FEED_FILT: begin
               if (filter_done_in) begin
                  state_q  <= S_ERROR;
                  src_rd_q <= 1'b0;
                  err_q    <= 1'b1;
                  code_q   <= E_EARLY;
               end else if (fstart_q) begin
                  src_rd_q  <= 1'b1;
                  src_idx_q <= '0;
               end else if (src_rd_q) begin
                  if (src_idx_q == SRC_LAST) begin
                     src_rd_q <= 1'b0;
                     state_q  <= S_DRAIN_FILT;
                  end else begin
                     src_idx_q <= src_idx_q + 9'd1;
                  end
               end
            end
            S_DRAIN_FILT: begin
               if (filter_done_in) begin
                  if (fcnt_d == DST_CNT) begin
                     state_q  <= S_FEED_GEN;
                     gstart_q <= 1'b1;
                  end else begin
                     state_q <= S_ERROR;
                     err_q   <= 1'b1;
                     code_q  <= E_COUNT;
                  end
               end else if (wd_trip) begin
                  state_q <= S_ERROR;
                  err_q   <= 1'b1;
                  code_q  <= E_TMO;
               end
            end
            S_FEED_GEN: begin
               if (gen_done_in) begin
                  state_q  <= S_ERROR;
                  gen_rd_q <= 1'b0;
                  err_q    <= 1'b1;
                  code_q   <= E_EARLY;
               end else if (gstart_q) begin
                  gen_rd_q  <= 1'b1;
                  gen_idx_q <= '0;
               end else if (gen_rd_q) begin
                  if (gen_idx_q == DST_LAST) begin
                     gen_rd_q <= 1'b0;
                     state_q  <= S_DRAIN_GEN;
                  end else begin
                     gen_idx_q <= gen_idx_q + 5'd1;
                  end
               end
            end
            S_DRAIN_GEN: begin
               if (gen_done_in) begin
                  if (ccnt_d == CON_CNT) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_ERROR;
                     err_q   <= 1'b1;
                     code_q  <= E_COUNT;
                  end
               end else if (wd_trip) begin
                  state_q <= S_ERROR;
                  err_q   <= 1'b1;
                  code_q  <= E_TMO;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      src_rd_en_out        = src_rd_q;
      src_row_idx_out      = src_idx_q;
      filter_start_out     = fstart_q;
      filter_row_valid_out = fvalid_q;
      rescale_wr_en_out    = f_acc && (fcnt_q < DST_CNT);
      rescale_wr_idx_out   = fcnt_q;
      gen_rd_en_out        = gen_rd_q;
      gen_row_idx_out      = gen_idx_q;
      gen_start_out        = gstart_q;
      gen_row_valid_out    = gvalid_q;
      con_wr_en_out        = g_acc && (ccnt_q < CON_CNT);
      con_wr_idx_out       = ccnt_q;
      state_out            = state_q;
      busy_out             = (state_q == S_FEED_FILT)  ||
                             (state_q == S_DRAIN_FILT) ||
                             (state_q == S_FEED_GEN)   ||
                             (state_q == S_DRAIN_GEN);
      done_out             = done_q;
      err_out              = err_q;
      err_code_out         = code_q;
   end

endmodule

// File: doc/puzzle_build_sequencer.md
# puzzle_build_sequencer

Controller that sequences the puzzle-build datapath: it streams the binarised camera photo (SRC_ROWS rows) through the rescale filter, captures the rescaled rows, then streams those rows through the constraint generator and captures its constraint lines. It owns every start pulse, read address and write strobe for the photo buffer, rescaled-row store and constraint store. It replaces the ad-hoc index/state logic in the top level. It reports progress, completion and fault status to the top-level mode logic and the 7-segment debug display.

## Interface
- SRC_ROWS, 240, photo rows fed to filter
- DST_ROWS, 30, rescaled rows expected from filter / fed to generator
- CON_LINES, 70, constraint lines expected from generator
- TIMEOUT_CYCLES, 4096, watchdog limit in drain states
- clk_in  in  1  system clock (65 MHz domain); one clock
- reset_in  in  1  synchronous, active-high reset
- start_in  in  1  one-cycle build request; ignored unless IDLE, DONE or ERROR
- abort_in  in  1  cancel build, return to IDLE
- src_rd_en_out / src_row_idx_out  out  1 / 9  photo buffer read strobe and row address
- filter_start_out  out  1  one-cycle filter start pulse
- filter_row_valid_out  out  1  photo row data on buffer output is valid for filter
- filter_outputing_in / filter_done_in  in  1 / 1  filter output strobe / completion
- rescale_wr_en_out / rescale_wr_idx_out  out  1 / 5  rescaled-row store write
- gen_rd_en_out / gen_row_idx_out  out  1 / 5  rescaled-row store read
- gen_start_out  out  1  one-cycle generator start pulse
- gen_row_valid_out  out  1  rescaled row valid for generator
- gen_outputing_in / gen_done_in  in  1 / 1  generator output strobe / completion
- con_wr_en_out / con_wr_idx_out  out  1 / 7  constraint store write
- state_out  out  3  current state encoding
- busy_out / done_out  out  1 / 1  build in progress / one-cycle completion pulse
- err_out / err_code_out  out  1 / 2  sticky fault, code: 0 none, 1 early done, 2 count mismatch, 3 timeout

## Operation
- States (encoding): IDLE 0, FEED_FILTER 1, DRAIN_FILTER 2, FEED_GEN 3, DRAIN_GEN 4, DONE 5, ERROR 6.
- IDLE/DONE/ERROR + start_in -> FEED_FILTER; clears counters, err_out, err_code_out.
- FEED_FILTER: filter_start_out pulses on entry cycle. One read per cycle, idx 0..SRC_ROWS-1, starting the cycle after entry. After the last read issues -> DRAIN_FILTER.
- filter_row_valid_out = src_rd_en_out delayed one cycle (buffer read latency 1).
- filter_outputing_in is accepted in FEED_FILTER and DRAIN_FILTER. Each strobe gives rescale_wr_en_out the same cycle (combinational) at idx = out count, then the count increments. Strobes beyond DST_ROWS suppress the write; the count still increments, saturating at 31.
- DRAIN_FILTER + filter_done_in: count == DST_ROWS -> FEED_GEN; otherwise -> ERROR, code 2.
- FEED_GEN / DRAIN_GEN mirror the filter states:
  - gen_start_out pulse on entry.
  - reads 0..DST_ROWS-1; gen_row_valid_out delayed one cycle.
  - con_wr_en_out per gen_outputing_in, writes capped at CON_LINES.
  - DRAIN_GEN + gen_done_in with count == CON_LINES -> DONE; done_out pulses on entry.
- Done strobe (filter_done_in or gen_done_in) in its FEED state -> ERROR, code 1.
- In ERROR, err_out stays high until next start_in or reset.
- abort_in in any state -> IDLE next cycle. All strobes low; no done_out. err_out is kept if already set.
- abort_in and start_in in the same cycle: abort wins.
- Done strobe and output strobe in the same cycle: the output is counted before the count check.
- busy_out high in states 1-4.

## Timing
- Reset values: all strobes/pulses 0, indices 0, state_out 0, busy_out 0, err_out 0, err_code_out 0.
- Build sequence, start_in at cycle t:
  - t+1: FEED_FILTER, filter_start_out high.
  - t+2..t+SRC_ROWS+1: src reads.
  - t+3..t+SRC_ROWS+2: filter_row_valid_out.
  - t+SRC_ROWS+2: DRAIN_FILTER.
- Generator phase, filter_done_in at cycle d: FEED_GEN at d+1, same offsets with DST_ROWS.
- DONE entered the cycle after the qualifying gen_done_in.
- Minimum build latency: SRC_ROWS + DST_ROWS + 6 cycles.

## Configuration
- SEQ_TIMEOUT_EN defined: in DRAIN_FILTER/DRAIN_GEN a counter runs, reset on every output strobe. Reaching TIMEOUT_CYCLES -> ERROR, code 3.
- SEQ_TIMEOUT_EN undefined: no watchdog; drain states wait indefinitely; code 3 never produced.

## Test plan
- Nominal: start pulse; filter model returns 30 strobes then done; generator returns 70 then done -> rescale writes idx 0..29, con writes idx 0..69, done_out one pulse, state 5, err_out 0.
- Pipeline timing: start at cycle 10 -> filter_start_out at 11, src idx 0 at 12, idx 239 at 251, filter_row_valid_out 13..252, state 2 at 252.
- Count mismatch: filter returns 31 strobes then done -> 31st write suppressed, ERROR, err_code_out 2; then start_in -> err cleared, FEED_FILTER.
- Early done: gen_done_in asserted during FEED_GEN row 5 -> ERROR, code 1, gen_rd_en_out low next cycle.
- Abort and reset mid-FEED_FILTER at row 100 -> IDLE next cycle, no further reads, no done_out. Same check for reset_in.
- With SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16: filter never asserts done -> ERROR code 3 exactly 16 cycles after last strobe. Without the macro: still DRAIN_FILTER after 10000 cycles.
